// File: rtl/key_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_scan_ctrl
//  Description : 4x4 matrix keypad scanner with debounce and valid/ready key
//                output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_scan_ctrl #(
    parameter int SCAN_CYCLES = 25_000,
    parameter int DEB_CNT     = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       busy
);

    localparam int              SCAN_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [19:0]     DEB_LAST  = 20'(DEB_CNT - 1);

    localparam logic [1:0] ST_SCAN         = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK     = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    logic [3:0]        col_meta_q;
    logic [3:0]        col_s_q;
    logic [1:0]        state_q,    state_d;
    logic [1:0]        row_q,      row_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [19:0]       deb_cnt_q,  deb_cnt_d;
    logic [1:0]        col_idx_q,  col_idx_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;

    logic [1:0]        first_low_col;
    logic              key_level;

    // Lowest-index pressed column wins when several are low together.
    always_comb begin
        first_low_col = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s_q[i]) begin
                first_low_col = 2'(i);
            end
        end
    end

    assign key_level = col_s_q[col_idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q  <= 4'hF;
            col_s_q     <= 4'hF;
            state_q     <= ST_SCAN;
            row_q       <= 2'd0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= 20'd0;
            col_idx_q   <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            col_meta_q  <= col_in;
            col_s_q     <= col_meta_q;
            state_q     <= state_d;
            row_q       <= row_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            col_idx_q   <= col_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        col_idx_d   = col_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        case (state_q)
            ST_SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (col_s_q == 4'hF) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        col_idx_d = first_low_col;
                        deb_cnt_d = 20'd0;
                        state_d   = ST_DEBOUNCE;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (key_level) begin
                    state_d = ST_SCAN;
                    row_d   = row_q + 2'd1;
                end else if (deb_cnt_q == DEB_LAST) begin
                    key_code_d  = {row_q, col_idx_q};
                    key_valid_d = 1'b1;
                    state_d     = ST_WAIT_ACK;
                end else begin
                    deb_cnt_d = deb_cnt_q + 20'd1;
                end
            end
            ST_WAIT_ACK: begin
                // The column is deliberately ignored here so a quick release
                // cannot cancel a key the consumer has not yet taken.
                if (key_ready) begin
                    key_valid_d = 1'b0;
                    deb_cnt_d   = 20'd0;
                    state_d     = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!key_level) begin
                    deb_cnt_d = 20'd0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = ST_SCAN;
                    row_d   = row_q + 2'd1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 20'd1;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    always_comb begin
        row_out   = ~(4'b0001 << row_q);
        busy      = (state_q != ST_SCAN);
        key_code  = key_code_q;
        key_valid = key_valid_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_scan_ctrl
//  Description : Keypad-model testbench with expected-key scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_scan_ctrl;

    localparam int SCAN_CYCLES = 4;
    localparam int DEB_CNT     = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       busy;

    logic [3:0] press [4];
    int         vectors = 0;
    int         miscompares = 0;
    int         exp_q [$];

    key_scan_ctrl #(
        .SCAN_CYCLES (SCAN_CYCLES),
        .DEB_CNT     (DEB_CNT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its column low only while its row is driven low.
    always_comb begin
        logic [3:0] acc;
        acc = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) acc = acc & ~press[r];
        end
        col_in = acc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_code(input int r, input logic [3:0] mask);
        for (int c = 0; c < 4; c++) begin
            if (mask[c]) return r * 4 + c;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (key_valid) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL valid_timeout: got key_valid=0 expected 1 within 200 clocks");
        end
    endtask

    task automatic wait_busy(input logic level);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (busy == level) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: got busy=%0b expected %0b within 200 clocks", busy, level);
        end
    endtask

    task automatic do_key(input int r, input logic [3:0] mask, input int rdy_dly, input bit early_rel);
        bit ok;
        exp_q.push_back(ref_code(r, mask));
        key_ready = (rdy_dly == 0);
        press[r]  = mask;
        wait_valid(ok);
        if (!ok) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < rdy_dly; i++) begin
                tick();
                if (early_rel && i == 2) press[r] = 4'h0;
            end
            key_ready = 1'b1;
            tick();
        end
        key_ready = 1'b1;
        press[r]  = 4'h0;
        wait_busy(1'b0);
        repeat (3) tick();
    endtask

    // Scoreboard monitor: pops an expected code on every handshake.
    initial begin
        int         cyc;
        int         entry_cyc;
        bit         prev_valid;
        bit         prev_busy;
        bit         hs_pending;
        logic [3:0] held_code;
        cyc = 0; entry_cyc = 0; prev_valid = 0; prev_busy = 0; hs_pending = 0;
        held_code = 4'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_valid = 0;
                prev_busy  = 0;
                hs_pending = 0;
            end else begin
                if (hs_pending) check("valid_after_ack", 32'(key_valid), 32'd0);
                if (busy && !prev_busy) entry_cyc = cyc;
                if (key_valid && !prev_valid) begin
                    check("valid_latency", cyc - entry_cyc, DEB_CNT);
                    held_code = key_code;
                end else if (key_valid && prev_valid) begin
                    check("code_stable", 32'(key_code), 32'(held_code));
                end
                if (key_valid && key_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_key: got code %0h expected no event", key_code);
                    end else begin
                        check("key_code", 32'(key_code), exp_q.pop_front());
                    end
                    hs_pending = 1;
                end else begin
                    hs_pending = 0;
                end
                prev_valid = key_valid;
                prev_busy  = busy;
            end
        end
    end

    initial begin
        bit ok;
        for (int r = 0; r < 4; r++) press[r] = 4'h0;
        #2;
        check("rst_row", 32'(row_out), 32'hE);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check("idle_row", 32'(row_out), 32'(4'hF & ~(4'h1 << ((k / 4) % 4))));
            check("idle_valid", 32'(key_valid), 32'd0);
        end

        do_key(1, 4'b0100, 0, 1'b0);

        // Short press that bounces off before the debounce window closes.
        key_ready = 1'b1;
        press[3]  = 4'b0001;
        wait_busy(1'b1);
        repeat (4) tick();
        press[3] = 4'h0;
        wait_busy(1'b0);
        check("bounce_row", 32'(row_out), 32'hE);
        check("bounce_valid", 32'(key_valid), 32'd0);
        repeat (10) tick();

        do_key(3, 4'b1000, 20, 1'b1);

        // Two keys on one row; a key on another row appears while held.
        key_ready = 1'b1;
        exp_q.push_back(ref_code(0, 4'b1010));
        press[0] = 4'b1010;
        wait_valid(ok);
        tick();
        press[2] = 4'b0001;
        repeat (5) tick();
        press[0] = 4'h0;
        press[2] = 4'h0;
        repeat (5) tick();
        check("multi_hold_busy", 32'(busy), 32'd1);
        wait_busy(1'b0);
        repeat (40) tick();

        for (int i = 0; i < 24; i++) begin
            do_key(int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                   int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        // Reset while a key is waiting for acknowledge.
        key_ready = 1'b0;
        exp_q.push_back(ref_code(2, 4'b0010));
        press[2] = 4'b0010;
        wait_valid(ok);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("rst_ack_valid", 32'(key_valid), 32'd0);
        check("rst_ack_row", 32'(row_out), 32'hE);
        check("rst_ack_busy", 32'(busy), 32'd0);
        check("rst_ack_code", 32'(key_code), 32'd0);
        exp_q.delete();
        press[2]  = 4'h0;
        key_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_row", 32'(row_out), 32'hE);
        do_key(2, 4'b0110, 2, 1'b0);

        repeat (20) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
